// File: rtl/writeback_arbiter.sv
// writeback_arbiter: collects completed ALU and MEM results into a small
// in-order FIFO and retires one per cycle onto the register file write port.
// The write outputs are registered. reset_write_addr mirrors the write index
// so the register file clears the busy bit on the same edge it writes the data.
module writeback_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         mem_valid,
  input  logic [ADDR_WIDTH-1:0]        mem_rd,
  input  logic [DATA_WIDTH-1:0]        mem_data,
  output logic                         mem_ready,
  input  logic                         alu_valid,
  input  logic [ADDR_WIDTH-1:0]        alu_rd,
  input  logic [DATA_WIDTH-1:0]        alu_data,
  output logic                         alu_ready,
  output logic                         write_enable,
  output logic [ADDR_WIDTH-1:0]        write_addr,
  output logic [DATA_WIDTH-1:0]        write_data,
  output logic [ADDR_WIDTH-1:0]        reset_write_addr,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  // FIFO storage (not reset: validity is tracked by occupancy alone)
  logic [ADDR_WIDTH-1:0] rd_mem_reg   [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_reg [DEPTH];

  logic [PTR_W-1:0]      head_reg, head_next;
  logic [PTR_W-1:0]      tail_reg, tail_next;
  logic [PTR_W-1:0]      alu_slot;
  logic [OCC_W-1:0]      occ_reg, occ_next;
  logic [OCC_W-1:0]      free;
  logic                  mem_push, alu_push, pop;
  logic [DEPTH-1:0]      mem_wr_sel, alu_wr_sel;

  logic                  we_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] data_reg;

  // Ready, push/pop decisions and pointer/occupancy updates; readies depend
  // only on registered occupancy, so a same-cycle pop never frees a slot.
  // An x0 result is accepted but skipped, yet still counts against free space.
  always_comb begin
    free      = OCC_W'(DEPTH) - occ_reg;
    mem_ready = (free >= OCC_W'(1));
    alu_ready = (free >= OCC_W'(2)) || ((free == OCC_W'(1)) && !mem_valid);
    mem_push  = mem_valid && mem_ready && (mem_rd != '0);
    alu_push  = alu_valid && alu_ready && (alu_rd != '0);
    pop       = (occ_reg != '0);
    // MEM takes the older slot; ALU lands right behind it
    alu_slot  = tail_reg + PTR_W'(mem_push);
    tail_next = tail_reg + PTR_W'(mem_push) + PTR_W'(alu_push);
    head_next = head_reg + PTR_W'(pop);
    occ_next  = occ_reg + OCC_W'(mem_push) + OCC_W'(alu_push) - OCC_W'(pop);
  end

  // Per-slot write selects; MEM and ALU never target the same slot
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot_sel
      assign mem_wr_sel[gi] = mem_push && (tail_reg == PTR_W'(gi));
      assign alu_wr_sel[gi] = alu_push && (alu_slot == PTR_W'(gi));
    end
  endgenerate

  // Slot storage writes
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_wr_sel[i]) begin
        rd_mem_reg[i]   <= mem_rd;
        data_mem_reg[i] <= mem_data;
      end else if (alu_wr_sel[i]) begin
        rd_mem_reg[i]   <= alu_rd;
        data_mem_reg[i] <= alu_data;
      end
    end
  end

  // Pointers, occupancy and the registered write port; address/data hold
  // their last value when nothing is popped
  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg <= '0;
      tail_reg <= '0;
      occ_reg  <= '0;
      we_reg   <= 1'b0;
      addr_reg <= '0;
      data_reg <= '0;
    end else begin
      head_reg <= head_next;
      tail_reg <= tail_next;
      occ_reg  <= occ_next;
      we_reg   <= pop;
      if (pop) begin
        addr_reg <= rd_mem_reg[head_reg];
        data_reg <= data_mem_reg[head_reg];
      end
    end
  end

  assign write_enable     = we_reg;
  assign write_addr       = addr_reg;
  assign write_data       = data_reg;
  assign reset_write_addr = we_reg ? addr_reg : '0;
  assign occupancy        = occ_reg;
  assign empty            = (occ_reg == '0) && !we_reg;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: accepted results go into a
// scoreboard queue and are compared in order as the write port retires them.
module tb_writeback_arbiter;

  localparam int AW    = 5;
  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int OW    = $clog2(DEPTH+1);

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_valid, alu_valid;
  logic [AW-1:0] mem_rd, alu_rd;
  logic [DW-1:0] mem_data, alu_data;
  logic          mem_ready, alu_ready;
  logic          write_enable;
  logic [AW-1:0] write_addr, reset_write_addr;
  logic [DW-1:0] write_data;
  logic [OW-1:0] occupancy;
  logic          empty;

  always #5 clk = ~clk;

  writeback_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .mem_valid        (mem_valid),
    .mem_rd           (mem_rd),
    .mem_data         (mem_data),
    .mem_ready        (mem_ready),
    .alu_valid        (alu_valid),
    .alu_rd           (alu_rd),
    .alu_data         (alu_data),
    .alu_ready        (alu_ready),
    .write_enable     (write_enable),
    .write_addr       (write_addr),
    .write_data       (write_data),
    .reset_write_addr (reset_write_addr),
    .occupancy        (occupancy),
    .empty            (empty)
  );

  wb_t           sb[$];
  int            checks = 0;
  int            errors = 0;
  int            model_occ = 0;
  logic          model_we = 1'b0;
  int            peak_occ = 0;
  int            model_peak = 0;
  logic          mem_acc_q, alu_acc_q;
  logic [DW-1:0] regfile [32];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    mem_valid = 1'b0;
    alu_valid = 1'b0;
  endtask

  // One clock: check outputs at negedge, record acceptances, advance model
  task automatic cycle();
    int   free;
    int   pushes;
    logic exp_mr, exp_ar;
    wb_t  e;
    @(negedge clk);
    check("write_enable", write_enable, model_we);
    if (model_we && sb.size() > 0) begin
      e = sb.pop_front();
      check("write_addr", write_addr, e.rd);
      check("write_data", write_data, e.data);
      check("reset_write_addr", reset_write_addr, e.rd);
      $display("write rd=%0d data=%0h", write_addr, write_data);
      regfile[write_addr] = write_data;
    end else begin
      check("reset_write_addr_idle", reset_write_addr, 0);
    end
    check("occupancy", occupancy, model_occ);
    check("empty", empty, (model_occ == 0) && !model_we);
    if (int'(occupancy) > peak_occ) peak_occ = int'(occupancy);
    if (model_occ > model_peak) model_peak = model_occ;
    free   = DEPTH - model_occ;
    exp_mr = (free >= 1);
    exp_ar = (free >= 2) || (free == 1 && !mem_valid);
    check("mem_ready", mem_ready, exp_mr);
    check("alu_ready", alu_ready, exp_ar);
    mem_acc_q = mem_valid && exp_mr;
    alu_acc_q = alu_valid && exp_ar;
    pushes = 0;
    if (mem_acc_q && mem_rd != 0) begin
      sb.push_back(wb_t'{rd: mem_rd, data: mem_data});
      pushes++;
    end
    if (alu_acc_q && alu_rd != 0) begin
      sb.push_back(wb_t'{rd: alu_rd, data: alu_data});
      pushes++;
    end
    @(posedge clk);
    if (reset) begin
      model_occ = 0;
      model_we  = 1'b0;
      sb.delete();
    end else begin
      model_we  = (model_occ > 0);
      model_occ = model_occ + pushes - (model_we ? 1 : 0);
    end
    #1;
  endtask

  initial begin
    int m_i, a_i;
    for (int i = 0; i < 32; i++) regfile[i] = '0;
    reset = 1'b1;
    idle();
    mem_rd = '0; alu_rd = '0; mem_data = '0; alu_data = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_write_enable", write_enable, 0);
    check("rst_write_addr", write_addr, 0);
    check("rst_write_data", write_data, 0);
    check("rst_reset_write_addr", reset_write_addr, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_empty", empty, 1);
    check("rst_mem_ready", mem_ready, 1);
    check("rst_alu_ready", alu_ready, 1);

    // single ALU write
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
    cycle();
    idle();
    repeat (4) cycle();
    check("single_reg5", regfile[5], 64'h1234);

    // simultaneous push to the same rd: younger (ALU) value wins
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 64'hAA;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'hBB;
    cycle();
    idle();
    repeat (4) cycle();
    check("simul_reg3", regfile[3], 64'hBB);

    // back-pressure: both producers hold valid, advancing only on acceptance
    peak_occ = 0; model_peak = 0;
    m_i = 1; a_i = 2;
    for (int c = 0; c < 6; c++) begin
      mem_valid = 1'b1; mem_rd = AW'(m_i); mem_data = 64'hB000 + 64'(m_i);
      alu_valid = 1'b1; alu_rd = AW'(a_i); alu_data = 64'hB000 + 64'(a_i);
      cycle();
      if (mem_acc_q) m_i += 2;
      if (alu_acc_q) a_i += 2;
    end
    idle();
    repeat (6) cycle();
    check("bp_drained", sb.size(), 0);
    check("bp_peak", peak_occ, model_peak);
    check("bp_peak_le_depth", peak_occ <= DEPTH, 1);
    check("bp_reg11", regfile[11], 64'hB00B);

    // x0 result is accepted but never written
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hDEAD;
    cycle();
    idle();
    repeat (3) cycle();
    check("x0_reg0", regfile[0], 0);

    // reset while entries are queued: queued entries must never appear
    for (int c = 0; c < 3; c++) begin
      mem_valid = 1'b1; mem_rd = AW'(20 + 2*c); mem_data = 64'hC000 + 64'(c);
      alu_valid = 1'b1; alu_rd = AW'(21 + 2*c); alu_data = 64'hD000 + 64'(c);
      cycle();
    end
    idle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("mid_rst_write_enable", write_enable, 0);
    check("mid_rst_occupancy", occupancy, 0);
    check("mid_rst_mem_ready", mem_ready, 1);
    check("mid_rst_alu_ready", alu_ready, 1);
    repeat (5) cycle();

    // stream across pointer wrap
    peak_occ = 0;
    for (int r = 1; r <= 10; r++) begin
      alu_valid = 1'b1; alu_rd = AW'(r); alu_data = 64'(r * 16);
      cycle();
    end
    idle();
    repeat (4) cycle();
    check("wrap_drained", sb.size(), 0);
    check("wrap_peak_le_2", peak_occ <= 2, 1);
    check("wrap_reg10", regfile[10], 64'hA0);
    check("wrap_reg4", regfile[4], 64'h40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
